// File: rtl/flick_scheduler_pkg.sv
// Shared definitions for the flasher and the schedulers that front it:
// flasher state encodings, scheduler state codes and the default requester count.
package flasher_pkg;

  // Default number of requesters sharing one flasher.
  localparam int DEF_N_REQ = 4;

  // Bound_Flasher current_state encodings; only FL_ST_IDLE matters to the scheduler.
  localparam logic [1:0] FL_ST_IDLE = 2'd0;
  localparam logic [1:0] FL_ST_UP   = 2'd1;
  localparam logic [1:0] FL_ST_DOWN = 2'd2;
  localparam logic [1:0] FL_ST_HOLD = 2'd3;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    SCH_IDLE       = 2'd0,
    SCH_ISSUE      = 2'd1,
    SCH_WAIT_START = 2'd2,
    SCH_WAIT_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/flick_scheduler_if.sv
// Requester/flasher-side signal bundle of the flick scheduler.
// master = the system driving requests and flasher status, slave = the scheduler.
interface flick_scheduler_if #(
  parameter int N_REQ = flasher_pkg::DEF_N_REQ
);
  logic [N_REQ-1:0] req;
  logic [1:0]       fl_state;
  logic             flick;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] pending;
  logic             busy;
  logic [N_REQ-1:0] ovf;
  logic             start_err;

  modport master (
    output req,
    output fl_state,
    input  flick,
    input  grant,
    input  pending,
    input  busy,
    input  ovf,
    input  start_err
  );

  modport slave (
    input  req,
    input  fl_state,
    output flick,
    output grant,
    output pending,
    output busy,
    output ovf,
    output start_err
  );
endinterface

// File: rtl/flick_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit at or
// above ptr, wrapping modulo N. Works by rotating the request vector down so
// ptr lands at bit 0, doing a plain priority pick, then rotating back up.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   oh_rot;
  logic [N:0]     seen;
  logic [2*N-1:0] oh_dbl;

  // Rotate requests so the pointer position becomes the highest priority bit 0.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N-1:0];

  // Fixed-priority pick on the rotated vector; seen[k] = any request below k.
  assign seen[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pick
      assign oh_rot[gi]   = req_rot[gi] & ~seen[gi];
      assign seen[gi + 1] = seen[gi] | req_rot[gi];
    end
  endgenerate

  // Rotate the one-hot pick back into requester numbering.
  assign oh_dbl = {oh_rot, oh_rot} << ptr;
  assign grant  = oh_dbl[2*N-1:N];
  assign valid  = seen[N];

endmodule

// File: rtl/flick_scheduler.sv
// Shares one Bound_Flasher between N_REQ requesters: captures request rising
// edges, picks a pending requester round-robin, issues a single-cycle flick
// and holds a one-hot grant until the flasher reports idle again.
module flick_scheduler
  import flasher_pkg::*;
#(
  parameter int         N_REQ    = DEF_N_REQ,
  parameter logic [1:0] FL_IDLE  = FL_ST_IDLE,
  parameter int         START_TO = 8,
  parameter int         TO_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  flick_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE       = SCH_IDLE;
  localparam logic [1:0] ST_ISSUE      = SCH_ISSUE;
  localparam logic [1:0] ST_WAIT_START = SCH_WAIT_START;
  localparam logic [1:0] ST_WAIT_DONE  = SCH_WAIT_DONE;

  logic [1:0]       state_reg,     state_next;
  logic [N_REQ-1:0] req_d_reg;
  logic [N_REQ-1:0] pending_reg,   pending_next;
  logic [N_REQ-1:0] ovf_reg,       ovf_next;
  logic [N_REQ-1:0] grant_reg,     grant_next;
  logic [PTR_W-1:0] ptr_reg,       ptr_next;
  logic [TO_W-1:0]  to_cnt_reg,    to_cnt_next;
  logic             start_err_reg, start_err_next;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] arb_grant;
  logic             arb_valid;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] ptr_after;
  logic             fl_is_idle;
  logic             to_expired;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (pending_reg),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign rise       = bus.req & ~req_d_reg;
  assign fl_is_idle = (bus.fl_state == FL_IDLE);
  assign to_expired = (to_cnt_reg == TO_W'(START_TO - 1));

  // Per-requester capture: a new edge always wins over the grant-time clear,
  // and only counts as an overflow if the bit was already queued and is not
  // being consumed in this same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cap
      assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
      assign ovf_next[gi]     = ovf_reg[gi] | (rise[gi] & pending_reg[gi] & ~clr[gi]);
    end
  endgenerate

  // Index of the current owner, used to advance the round-robin pointer.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_reg[i]) begin
        owner_idx = PTR_W'(i);
      end
    end
  end

  assign ptr_after = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

  // Sequencing: pick a winner, flick once, wait for the flasher to start, then finish.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    ptr_next       = ptr_reg;
    to_cnt_next    = to_cnt_reg;
    start_err_next = 1'b0;
    clr            = '0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_next = arb_grant;
          clr        = arb_grant;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_cnt_next = '0;
        state_next  = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!fl_is_idle) begin
          state_next = ST_WAIT_DONE;
        end else if (to_expired) begin
          // Flasher never responded: drop this request and move on.
          start_err_next = 1'b1;
          grant_next     = '0;
          ptr_next       = ptr_after;
          state_next     = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (fl_is_idle) begin
          grant_next = '0;
          ptr_next   = ptr_after;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      req_d_reg     <= '0;
      pending_reg   <= '0;
      ovf_reg       <= '0;
      grant_reg     <= '0;
      ptr_reg       <= '0;
      to_cnt_reg    <= '0;
      start_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_d_reg     <= bus.req;
      pending_reg   <= pending_next;
      ovf_reg       <= ovf_next;
      grant_reg     <= grant_next;
      ptr_reg       <= ptr_next;
      to_cnt_reg    <= to_cnt_next;
      start_err_reg <= start_err_next;
    end
  end

  assign bus.flick     = (state_reg == ST_ISSUE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.grant     = grant_reg;
  assign bus.pending   = pending_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.start_err = start_err_reg;

endmodule

// File: doc/flick_scheduler.md
Name: flick_scheduler

Overview:
- Shares one Bound_Flasher instance between N_REQ independent flick requesters.
- Captures the rising edge of each requester, then picks one pending requester using round-robin arbitration.
- Issues a one-cycle flick pulse to the flasher and holds a one-hot grant until the flasher returns to its idle state.
- Sits directly in front of the flasher's flick input and monitors the flasher's current_state output.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FL_IDLE, 2'd0, flasher current_state encoding that means idle/sequence complete.
- START_TO, 8, cycles to wait for the flasher to leave FL_IDLE after a flick before declaring a start error.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > START_TO.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; only the rising edge counts.
- fl_state  in  2  flasher current_state.
- flick  out  1  one-cycle pulse to the flasher flick input.
- grant  out  N_REQ  one-hot owner of the current flasher sequence; zero when no sequence is active.
- pending  out  N_REQ  captured requests not yet served.
- busy  out  1  high in any state other than IDLE.
- ovf  out  N_REQ  sticky per requester: a new edge arrived while that requester's pending bit was already set.
- start_err  out  1  one-cycle pulse on a START_TO expiry.

Behaviour:
- Reset (synchronous, active-high, dominant over all other activity):
  - state=IDLE; req_d, pending, grant, ovf = 0; flick=0; start_err=0; rr pointer=0; timeout counter=0.
  - Reset applied mid-sequence abandons the sequence. No flick is emitted during or after reset.
- Edge capture, every cycle: rise = req & ~req_d; req_d <= req.
  - rise[i] sets pending[i].
  - rise[i] while pending[i]=1 also sets ovf[i]. The request is not queued twice.
  - If the cycle that clears pending[i] (grant issue) also sees rise[i], the set wins: pending[i] stays 1 and ovf is not set.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE. flick and busy are decoded from the registered state.
- IDLE:
  - If pending != 0, select the winner w.
  - w is the first set bit of pending, searching upward from the rr pointer and wrapping modulo N_REQ.
  - On that edge: grant <= onehot(w), pending[w] cleared, state <= ISSUE.
- ISSUE: flick=1 for exactly this one cycle; timeout counter <= 0; next state WAIT_START.
- WAIT_START:
  - If fl_state != FL_IDLE, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TO-1:
    - start_err pulses for one cycle, grant <= 0, pointer <= w+1 mod N_REQ, state <= IDLE.
    - The request is dropped, not retried.
- WAIT_DONE:
  - When fl_state == FL_IDLE: grant <= 0, pointer <= w+1 mod N_REQ, state <= IDLE.
  - No timeout; the flasher sequence length is unbounded.
- Latency:
  - A rise sampled at edge E0 while IDLE produces pending=1 after E0, state=ISSUE after E1, and flick high between E1 and E2.
  - Minimum turnaround between consecutive flicks is 4 cycles plus the flasher sequence duration.
- Rises during a busy sequence are only captured in pending; they never extend or restart the current sequence.
- grant is stable from the ISSUE state until the return to IDLE.

Decomposition:
- Package flasher_pkg holds:
  - FL_IDLE and the other flasher state encodings.
  - The scheduler state enum (2-bit).
  - Default N_REQ.
- One sub-module, rr_arbiter: combinational; inputs req vector and pointer; outputs one-hot grant and a valid flag. Reusable by other shared-resource controllers in the design.

Test Plan:
- Reset held for 3 cycles with req=4'b1111 toggling -> all outputs 0, flick never high; after release, with no new edge, pending stays 0.
- req[2] rising at cycle 10, flasher model leaves FL_IDLE 2 cycles after flick and returns 20 cycles later -> flick is a single-cycle pulse after the second edge; grant=4'b0100 until fl_state==FL_IDLE; then grant=0 and busy=0.
- req 0, 1 and 3 rising together while idle, pointer=0 -> grants issued in order 4'b0001, 4'b0010, 4'b1000; exactly 3 flick pulses.
- req[1] pulsed twice while busy serving req[0] -> pending[1]=1, ovf[1]=1; only one later grant of 4'b0010.
- Flasher model never leaves FL_IDLE -> start_err pulses after START_TO=8 cycles in WAIT_START; state returns to IDLE; the next pending requester is served.
- Reset asserted in WAIT_DONE with pending=4'b0110 -> next cycle all state cleared; no flick until a fresh rising edge.
